execute: RTL and testbench

- Execute (EX) stage of the 16-bit pipelined CPU; sits between decode/register-read and memory/writeback.
- Performs the ALU operation selected by the opcode, computes branch targets, and updates compare flags.
- Registers results, destination index and control into the EX/MEM pipeline register.

---
 rtl/cpu_pkg.sv | 42 ++++
 rtl/execute_alu.sv | 58 +++++
 rtl/execute.sv | 99 +++++++++
 tb/tb_execute.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 16-bit pipelined CPU: datapath widths, the
// 4-bit opcode encodings carried in control[3:0], and the compare-flag
// record held by the execute stage.
// ---------------------------------------------------------------------------
package cpu_pkg;

   localparam int DATA_W = 16;
   localparam int IMM_W  = 7;
   localparam int IDX_W  = 5;
   localparam int CTL_W  = 5;

   localparam logic [3:0] OP_NOP    = 4'd0;
   localparam logic [3:0] OP_SUB    = 4'd1;
   localparam logic [3:0] OP_ADD    = 4'd2;
   localparam logic [3:0] OP_ADDI   = 4'd3;
   localparam logic [3:0] OP_SHLLI  = 4'd4;
   localparam logic [3:0] OP_SHRLI  = 4'd5;
   localparam logic [3:0] OP_JUMP   = 4'd6;
   localparam logic [3:0] OP_JUMPL  = 4'd7;
   localparam logic [3:0] OP_JUMPG  = 4'd8;
   localparam logic [3:0] OP_JUMPE  = 4'd9;
   localparam logic [3:0] OP_JUMPNE = 4'd10;
   localparam logic [3:0] OP_CMP    = 4'd11;
   localparam logic [3:0] OP_LOAD   = 4'd12;
   localparam logic [3:0] OP_LOADI  = 4'd13;
   localparam logic [3:0] OP_STORE  = 4'd14;
   localparam logic [3:0] OP_MOV    = 4'd15;

   typedef struct packed {
      logic zf;
      logic gf;
      logic lf;
   } flags_t;

   // Sign-extend the immediate field to the datapath width.
   function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
      return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
   endfunction

endpackage

// File: rtl/execute_alu.sv
// ---------------------------------------------------------------------------
// execute_alu
// Combinational ALU of the EX stage. Decodes the 4-bit opcode and produces
// the result (ALU value or memory address), the writeback enable and the
// signed compare of a against b. The compare outputs are always live; the
// caller decides when to capture them.
//   i_opcode  [3:0]  opcode (control[3:0])
//   i_a       [15:0] operand A (reg1)
//   i_b       [15:0] operand B (reg2)
//   i_imm     [6:0]  immediate field
//   o_result  [15:0] result / address
//   o_we             writeback enable
//   o_zf/o_gf/o_lf   a==b, a>b, a<b (signed)
// ---------------------------------------------------------------------------
module execute_alu
   import cpu_pkg::*;
(
   input  logic [3:0]        i_opcode,
   input  logic [DATA_W-1:0] i_a,
   input  logic [DATA_W-1:0] i_b,
   input  logic [IMM_W-1:0]  i_imm,
   output logic [DATA_W-1:0] o_result,
   output logic              o_we,
   output logic              o_zf,
   output logic              o_gf,
   output logic              o_lf
);

   logic [DATA_W-1:0] w_simm;
   logic [DATA_W-1:0] w_zimm;

   assign w_simm = sext_imm(i_imm);
   assign w_zimm = {{(DATA_W-IMM_W){1'b0}}, i_imm};

   assign o_zf = (i_a == i_b);
   assign o_gf = ($signed(i_a) > $signed(i_b));
   assign o_lf = ($signed(i_a) < $signed(i_b));

   always_comb begin
      o_result = '0;
      o_we     = 1'b0;
      unique case (i_opcode)
         OP_SUB:   begin o_result = i_a - i_b;             o_we = 1'b1; end
         OP_ADD:   begin o_result = i_a + i_b;             o_we = 1'b1; end
         OP_ADDI:  begin o_result = i_a + w_simm;          o_we = 1'b1; end
         OP_SHLLI: begin o_result = i_a << i_imm[3:0];     o_we = 1'b1; end
         OP_SHRLI: begin o_result = i_a >> i_imm[3:0];     o_we = 1'b1; end
         OP_LOAD:  begin o_result = i_a + w_simm;          o_we = 1'b1; end
         OP_LOADI: begin o_result = w_zimm;                o_we = 1'b1; end
         // Store address only; the data travels on output_reg.
         OP_STORE: begin o_result = i_a + w_simm;          o_we = 1'b0; end
         OP_MOV:   begin o_result = i_a;                   o_we = 1'b1; end
         // NOP, jumps and CMP produce no register result.
         default:  begin o_result = '0;                    o_we = 1'b0; end
      endcase
   end

endmodule

// File: rtl/execute.sv
// ---------------------------------------------------------------------------
// execute
// EX stage of the 16-bit pipelined CPU. Runs the ALU, forms the branch
// target npc + simm for every instruction, keeps the compare flags and
// registers everything into the EX/MEM pipeline register. One-cycle
// latency, no stall or flush: a new instruction is accepted every cycle.
//   clk, rst_n          clock, asynchronous active-low reset
//   control_in [4:0]    [3:0] opcode, [4] reserved (forwarded only)
//   dest_index_in [4:0] destination register index
//   reg1_data/reg2_data operands A / B (B also store data)
//   npc [15:0]          PC+1 of this instruction
//   immediate [6:0]     immediate field
//   dest_index_out, control_out, output_reg   registered pass-throughs
//   result_out, target, DEST_REG_WRITE_EN     registered ALU outputs
//   ZF, GF, LF          flags, updated only by CMP
// ---------------------------------------------------------------------------
module execute
   import cpu_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [CTL_W-1:0]  control_in,
   input  logic [IDX_W-1:0]  dest_index_in,
   input  logic [DATA_W-1:0] reg1_data,
   input  logic [DATA_W-1:0] reg2_data,
   input  logic [DATA_W-1:0] npc,
   input  logic [IMM_W-1:0]  immediate,
   output logic [IDX_W-1:0]  dest_index_out,
   output logic [CTL_W-1:0]  control_out,
   output logic [DATA_W-1:0] output_reg,
   output logic [DATA_W-1:0] result_out,
   output logic [DATA_W-1:0] target,
   output logic              DEST_REG_WRITE_EN,
   output logic              ZF,
   output logic              GF,
   output logic              LF
);

   logic [DATA_W-1:0] w_alu_result;
   logic              w_alu_we;
   flags_t            w_cmp_flags;
   logic [DATA_W-1:0] w_target;

   logic [IDX_W-1:0]  r_dest_index;
   logic [CTL_W-1:0]  r_control;
   logic [DATA_W-1:0] r_output_reg;
   logic [DATA_W-1:0] r_result;
   logic [DATA_W-1:0] r_target;
   logic              r_we;
   flags_t            r_flags;

   execute_alu u_alu (
      .i_opcode (control_in[3:0]),
      .i_a      (reg1_data),
      .i_b      (reg2_data),
      .i_imm    (immediate),
      .o_result (w_alu_result),
      .o_we     (w_alu_we),
      .o_zf     (w_cmp_flags.zf),
      .o_gf     (w_cmp_flags.gf),
      .o_lf     (w_cmp_flags.lf)
   );

   // Target is formed unconditionally; the taken decision is made downstream.
   assign w_target = npc + sext_imm(immediate);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dest_index <= '0;
         r_control    <= '0;
         r_output_reg <= '0;
         r_result     <= '0;
         r_target     <= '0;
         r_we         <= 1'b0;
         r_flags      <= '0;
      end else begin
         r_dest_index <= dest_index_in;
         r_control    <= control_in;
         r_output_reg <= reg2_data;
         r_result     <= w_alu_result;
         r_target     <= w_target;
         r_we         <= w_alu_we;
         // Flags persist across non-CMP instructions so a later jump can use them.
         if (control_in[3:0] == OP_CMP)
            r_flags <= w_cmp_flags;
      end
   end

   assign dest_index_out    = r_dest_index;
   assign control_out       = r_control;
   assign output_reg        = r_output_reg;
   assign result_out        = r_result;
   assign target            = r_target;
   assign DEST_REG_WRITE_EN = r_we;
   assign ZF                = r_flags.zf;
   assign GF                = r_flags.gf;
   assign LF                = r_flags.lf;

endmodule

// File: tb/tb_execute.sv
module tb_execute;

   logic        clk;
   logic        rst_n;
   logic [4:0]  control_in;
   logic [4:0]  dest_index_in;
   logic [15:0] reg1_data;
   logic [15:0] reg2_data;
   logic [15:0] npc;
   logic [6:0]  immediate;
   logic [4:0]  dest_index_out;
   logic [4:0]  control_out;
   logic [15:0] output_reg;
   logic [15:0] result_out;
   logic [15:0] target;
   logic        DEST_REG_WRITE_EN;
   logic        ZF;
   logic        GF;
   logic        LF;

   typedef struct packed {
      logic [4:0]  dest;
      logic [4:0]  ctl;
      logic [15:0] outreg;
      logic [15:0] result;
      logic [15:0] target;
      logic        we;
      logic        zf;
      logic        gf;
      logic        lf;
   } exp_t;

   exp_t exp_q[$];

   int n_checks = 0;
   int n_fail   = 0;

   // Bench-side flag state, changed only by CMP.
   logic m_zf = 1'b0;
   logic m_gf = 1'b0;
   logic m_lf = 1'b0;

   execute dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .control_in        (control_in),
      .dest_index_in     (dest_index_in),
      .reg1_data         (reg1_data),
      .reg2_data         (reg2_data),
      .npc               (npc),
      .immediate         (immediate),
      .dest_index_out    (dest_index_out),
      .control_out       (control_out),
      .output_reg        (output_reg),
      .result_out        (result_out),
      .target            (target),
      .DEST_REG_WRITE_EN (DEST_REG_WRITE_EN),
      .ZF                (ZF),
      .GF                (GF),
      .LF                (LF)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, " dest"},   {11'd0, dest_index_out}, 16'd0);
      chk({tag, " ctl"},    {11'd0, control_out},    16'd0);
      chk({tag, " outreg"}, output_reg,              16'd0);
      chk({tag, " result"}, result_out,              16'd0);
      chk({tag, " target"}, target,                  16'd0);
      chk({tag, " we"},     {15'd0, DEST_REG_WRITE_EN}, 16'd0);
      chk({tag, " flags"},  {13'd0, ZF, GF, LF},     16'd0);
   endtask

   // Drive one instruction, push its expectation, then pop and compare
   // just after the edge that registers it.
   task automatic step(input string tag, input logic [4:0] ctl, input logic [4:0] dest,
                       input logic [15:0] r1, input logic [15:0] r2, input logic [15:0] pc,
                       input logic [6:0] imm, input logic [15:0] exp_res, input logic exp_we);
      exp_t e;
      exp_t got;
      control_in    = ctl;
      dest_index_in = dest;
      reg1_data     = r1;
      reg2_data     = r2;
      npc           = pc;
      immediate     = imm;
      if (ctl[3:0] == 4'd11) begin
         m_zf = (r1 == r2);
         m_gf = ($signed(r1) > $signed(r2));
         m_lf = ($signed(r1) < $signed(r2));
      end
      e.dest   = dest;
      e.ctl    = ctl;
      e.outreg = r2;
      e.result = exp_res;
      e.target = pc + {{9{imm[6]}}, imm};
      e.we     = exp_we;
      e.zf     = m_zf;
      e.gf     = m_gf;
      e.lf     = m_lf;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      n_checks++;
      assert (exp_q.size() != 0) else begin
         n_fail++;
         $error("FAIL %s queue: observed empty expected entry", tag);
      end
      if (exp_q.size() != 0) begin
         got = exp_q.pop_front();
         chk({tag, " dest"},   {11'd0, dest_index_out}, {11'd0, got.dest});
         chk({tag, " ctl"},    {11'd0, control_out},    {11'd0, got.ctl});
         chk({tag, " outreg"}, output_reg,              got.outreg);
         chk({tag, " result"}, result_out,              got.result);
         chk({tag, " target"}, target,                  got.target);
         chk({tag, " we"},     {15'd0, DEST_REG_WRITE_EN}, {15'd0, got.we});
         chk({tag, " flags"},  {13'd0, ZF, GF, LF},     {13'd0, got.zf, got.gf, got.lf});
      end
   endtask

   initial begin
      logic [15:0] a;
      logic [15:0] b;
      control_in    = '0;
      dest_index_in = '0;
      reg1_data     = '0;
      reg2_data     = '0;
      npc           = '0;
      immediate     = '0;
      rst_n         = 1'b1;
      #1 rst_n = 1'b0;
      #1 check_zero("reset_async");
      @(posedge clk); #1;
      check_zero("reset_held");
      @(negedge clk);
      rst_n = 1'b1;

      // Directed instructions
      step("sub",      5'h01, 5'd2,  16'd10,     16'd3,      16'd0,   7'd0,   16'd7,      1'b1);
      step("add",      5'h02, 5'd3,  16'd10,     16'd5,      16'd0,   7'd0,   16'd15,     1'b1);
      step("addi",     5'h03, 5'd4,  16'd10,     16'd0,      16'd0,   7'd7,   16'd17,     1'b1);
      step("addi_neg", 5'h03, 5'd4,  16'd10,     16'd0,      16'd0,   7'h7F,  16'd9,      1'b1);
      step("shlli",    5'h04, 5'd5,  16'd8,      16'd0,      16'd0,   7'd1,   16'd16,     1'b1);
      step("shrli",    5'h05, 5'd5,  16'd8,      16'd0,      16'd0,   7'd1,   16'd4,      1'b1);
      step("shrli_15", 5'h05, 5'd5,  16'h8000,   16'd0,      16'd0,   7'd15,  16'd1,      1'b1);
      // CMP 5 vs 9 -> LF
      step("cmp_lt",   5'h0B, 5'd0,  16'd5,      16'd9,      16'd0,   7'd0,   16'd0,      1'b0);
      step("add_hold", 5'h02, 5'd6,  16'd10,     16'd5,      16'd0,   7'd0,   16'd15,     1'b1);
      // CMP 9 vs 5 -> GF
      step("cmp_gt",   5'h0B, 5'd0,  16'd9,      16'd5,      16'd0,   7'd0,   16'd0,      1'b0);
      // CMP -1 vs 1 -> LF (signed)
      step("cmp_sgn",  5'h0B, 5'd0,  16'hFFFF,   16'd1,      16'd0,   7'd0,   16'd0,      1'b0);
      // CMP 4 vs 4 -> ZF
      step("cmp_eq",   5'h0B, 5'd0,  16'd4,      16'd4,      16'd0,   7'd0,   16'd0,      1'b0);
      step("jump",     5'h06, 5'd0,  16'd1,      16'd2,      16'd100, 7'h7C,  16'd0,      1'b0);
      step("jumpl_r4", 5'h17, 5'd1,  16'd1,      16'd2,      16'd50,  7'd5,   16'd0,      1'b0);
      step("store",    5'h0E, 5'd0,  16'd20,     16'hBEEF,   16'd0,   7'd3,   16'd23,     1'b0);
      step("load",     5'h0C, 5'd7,  16'd100,    16'd0,      16'd0,   7'h7E,  16'd98,     1'b1);
      step("loadi",    5'h0D, 5'd8,  16'd0,      16'd0,      16'd0,   7'h7F,  16'd127,    1'b1);
      step("mov",      5'h0F, 5'd9,  16'hABCD,   16'd0,      16'd0,   7'd0,   16'hABCD,   1'b1);
      step("add_r4",   5'h12, 5'd31, 16'hFFFF,   16'd2,      16'hFFFE, 7'd3,  16'd1,      1'b1);
      step("nop",      5'h00, 5'd0,  16'd77,     16'd88,     16'd0,   7'd0,   16'd0,      1'b0);

      // Random ADD/SUB stream
      for (int i = 0; i < 16; i++) begin
         a = 16'($urandom_range(0, 65535));
         b = 16'($urandom_range(0, 65535));
         if ($urandom_range(0, 1) == 0)
            step("rnd_add", 5'h02, 5'($urandom_range(0, 31)), a, b, 16'($urandom_range(0, 65535)),
                 7'($urandom_range(0, 127)), a + b, 1'b1);
         else
            step("rnd_sub", 5'h01, 5'($urandom_range(0, 31)), a, b, 16'($urandom_range(0, 65535)),
                 7'($urandom_range(0, 127)), a - b, 1'b1);
      end

      // Establish nonzero flags, then reset mid-cycle
      step("cmp_pre",  5'h0B, 5'd0,  16'd3,      16'd3,      16'd10,  7'd1,   16'd0,      1'b0);
      step("mov_pre",  5'h0F, 5'd4,  16'h1234,   16'h5678,   16'd10,  7'd1,   16'h1234,   1'b1);
      @(negedge clk);
      rst_n = 1'b0;
      #1 check_zero("reset_mid");
      exp_q.delete();
      m_zf = 1'b0;
      m_gf = 1'b0;
      m_lf = 1'b0;
      @(posedge clk); #1;
      check_zero("reset_mid_held");
      @(negedge clk);
      rst_n = 1'b1;
      control_in    = 5'h02;
      dest_index_in = 5'd3;
      reg1_data     = 16'd1;
      reg2_data     = 16'd1;
      #1 check_zero("post_release");
      step("first_after", 5'h02, 5'd3, 16'd1, 16'd1, 16'd0, 7'd0, 16'd2, 1'b1);
      step("nop_end",     5'h00, 5'd0, 16'd5, 16'd6, 16'd0, 7'd0, 16'd0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
